note_sequencer: RTL and testbench
=================================

// Module: note_sequencer
// PURPOSE
//  Upstream feeder of the note display/draw stage. Records up to DEPTH notes (code+octave) from user entry.
//  Replays them at a fixed tempo, driving note/octave plus ld_note/ld_play strobes for the redraw stage.
//  In idle it passes live entry through so the display tracks the switches.
// PARAMETERS
//  DEPTH       16          recorded-note capacity (power of 2)
//  ADDR_W      4           log2(DEPTH)
//  NOTE_TICKS  25_000_000  clk cycles each played note is held (0.5 s @ 50 MHz); must be >= 2
//  TICK_W      25          width of tempo down-counter
// PORTS
//  clk          in   1       system clock, all logic on posedge
//  reset        in   1       asynchronous, active-high; clears all state
//  note_sw      in   4       entered note code: 0=rest, 1..12=A..G#, 13..15 invalid
//  octave_sw    in   2       entered octave (0..3 -> display 1..4)
//  ld_note      in   1       record request, level (synchronous to clk); rising edge acts
//  ld_play      in   1       play request, level; rising edge acts
//  stop         in   1       abort playback, level
//  clear        in   1       erase recording, level
//  note         out  4       note code to draw stage
//  octave       out  2       octave to draw stage
//  disp_ld_note out  1       to draw stage ld_note; registered copy of ld_note, idle only
//  disp_ld_play out  1       to draw stage ld_play; 1-cycle pulse per played step
//  playing      out  1       high in any PLAY_* state
//  count        out  ADDR_W+1  number of stored notes, 0..DEPTH
//  rec_reject   out  1       1-cycle pulse: record refused (full or invalid code)
// BEHAVIOUR
//  - Reset values: state IDLE, count 0, idx 0, note 0, octave 0, all strobes 0, playing 0. Memory not cleared.
//  - Edges: ev_x = x & ~x_q, x_q registered each cycle (reset 0). Held level acts once.
//  - Memory: DEPTH x 6 bits {octave,note}; synchronous write; registered read (1-cycle latency).
//  - States: IDLE, PLAY_RD, PLAY_SHOW, PLAY_HOLD.
//  - IDLE: note/octave <= note_sw/octave_sw each cycle; disp_ld_note <= ld_note.
//    ev_ld_note: if count<DEPTH and note_sw<=12, write mem[count], count+1 (visible next cycle);
//    else rec_reject pulses next cycle, count unchanged.
//    ev_ld_play with count>0: idx<=0 -> PLAY_RD. With count==0: ignored, stay IDLE.
//  - PLAY_RD: present mem[idx] to read register -> PLAY_SHOW (1 cycle).
//  - PLAY_SHOW: note/octave <= read data; disp_ld_play=1 for this single cycle; tick<=NOTE_TICKS-1 -> PLAY_HOLD.
//  - PLAY_HOLD: tick decrements; note/octave held stable. At tick==0: idx==count-1 -> end-of-sequence rule;
//    else idx+1 -> PLAY_RD. Step period = NOTE_TICKS+2 cycles; disp_ld_play to next pulse same.
//  - End of sequence (macro off): -> IDLE; outputs resume switch passthrough next cycle.
//  - disp_ld_note forced 0 in all PLAY_* states; ld_note edges ignored while playing (no write, no reject).
//  - Priority per cycle: reset > clear > stop > ld_play > ld_note.
//    clear (any state): count<=0, idx<=0, -> IDLE. stop in PLAY_*: -> IDLE next cycle, count kept.
//    ld_play and ld_note edges same cycle in IDLE: play taken, record dropped silently.
//  - count at DEPTH: saturates; further records rejected. idx never exceeds count-1.
//  - Reset mid-playback: immediate IDLE, count 0; no disp_ld_play pulse generated.
// CONFIGURATION
//  LOOP_PLAY_EN defined: at end of sequence idx<=0 -> PLAY_RD; playback repeats until stop/clear/reset.
//  LOOP_PLAY_EN undefined: single pass, return to IDLE after last note hold.
// TESTING (sim with NOTE_TICKS=4)
//  1 Reset: assert reset mid-cycle -> all outputs 0 immediately, count 0, state IDLE.
//  2 Record: note_sw=3,oct=1 ld_note pulse; note_sw=10,oct=2 pulse -> count=2, no rec_reject;
//    note_sw=14 pulse -> rec_reject 1 cycle, count stays 2.
//  3 Play: ld_play rising -> disp_ld_play pulses with {note,oct}={3,1} then {10,2}, 6 cycles apart; playing falls after
//    second hold; note/octave return to switches.
//  4 Full: 17 valid records with DEPTH=16 -> count=16, 17th gives rec_reject.
//  5 Conflicts: stop during PLAY_HOLD -> IDLE next cycle, count kept; same-cycle ld_play+ld_note -> plays, count unchanged;
//    clear during play -> count 0, IDLE.
//  6 LOOP_PLAY_EN on: 2-note recording -> pulses continue {3,1},{10,2},{3,1}... until stop.

Source files
------------

// File: rtl/note_sequencer.sv
// note_sequencer: records up to DEPTH {octave,note} entries and replays them
// at a fixed tempo to the note draw stage; passes live switches through in idle.
// Ports: clk, reset (async, active-high); note_sw/octave_sw entry switches;
//   ld_note/ld_play/stop/clear level requests; note/octave/disp_ld_note/
//   disp_ld_play to the draw stage; playing, count, rec_reject status.
// Build option: define LOOP_PLAY_EN to repeat playback until stop/clear/reset.
module note_sequencer #(
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4,
  parameter int NOTE_TICKS = 25_000_000,
  parameter int TICK_W     = 25
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        note_sw,
  input  logic [1:0]        octave_sw,
  input  logic              ld_note,
  input  logic              ld_play,
  input  logic              stop,
  input  logic              clear,
  output logic [3:0]        note,
  output logic [1:0]        octave,
  output logic              disp_ld_note,
  output logic              disp_ld_play,
  output logic              playing,
  output logic [ADDR_W:0]   count,
  output logic              rec_reject
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY_RD,
    S_PLAY_SHOW,
    S_PLAY_HOLD
  } state_t;

  localparam logic [ADDR_W:0]   LP_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   LP_ONE   = (ADDR_W+1)'(1);
  localparam logic [TICK_W-1:0] LP_TICK  = TICK_W'(NOTE_TICKS - 1);

  state_t r_state, w_state_nxt;

  logic              r_ld_note_q, r_ld_play_q;
  logic [5:0]        r_mem [DEPTH];
  logic [5:0]        r_rd;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W:0]   r_count;
  logic [TICK_W-1:0] r_tick;
  logic [3:0]        r_note;
  logic [1:0]        r_octave;
  logic              r_disp_ld_note, r_disp_ld_play, r_rec_reject;

  logic w_ev_note, w_ev_play, w_last;
  logic w_wr, w_rej, w_start, w_show, w_adv;

  assign w_ev_note = ld_note & ~r_ld_note_q;
  assign w_ev_play = ld_play & ~r_ld_play_q;
  assign w_last    = ({1'b0, r_idx} == (r_count - LP_ONE));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // clear beats stop beats play beats record
  always_comb begin
    w_state_nxt = r_state;
    w_wr        = 1'b0;
    w_rej       = 1'b0;
    w_start     = 1'b0;
    w_show      = 1'b0;
    w_adv       = 1'b0;
    if (clear) begin
      w_state_nxt = S_IDLE;
    end else if (stop && r_state != S_IDLE) begin
      w_state_nxt = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_ev_play && r_count != '0) begin
            w_start     = 1'b1;
            w_state_nxt = S_PLAY_RD;
          end else if (w_ev_note) begin
            if (r_count < LP_DEPTH && note_sw <= 4'd12) w_wr  = 1'b1;
            else                                        w_rej = 1'b1;
          end
        end
        S_PLAY_RD: w_state_nxt = S_PLAY_SHOW;
        S_PLAY_SHOW: begin
          w_show      = 1'b1;
          w_state_nxt = S_PLAY_HOLD;
        end
        S_PLAY_HOLD: begin
          if (r_tick == '0) begin
            if (w_last) begin
`ifdef LOOP_PLAY_EN
              w_start     = 1'b1;
              w_state_nxt = S_PLAY_RD;
`else
              w_state_nxt = S_IDLE;
`endif
            end else begin
              w_adv       = 1'b1;
              w_state_nxt = S_PLAY_RD;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // recording memory is not reset; the read register follows idx every cycle
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_count[ADDR_W-1:0]] <= {octave_sw, note_sw};
    r_rd <= r_mem[r_idx];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ld_note_q    <= 1'b0;
      r_ld_play_q    <= 1'b0;
      r_idx          <= '0;
      r_count        <= '0;
      r_tick         <= '0;
      r_note         <= '0;
      r_octave       <= '0;
      r_disp_ld_note <= 1'b0;
      r_disp_ld_play <= 1'b0;
      r_rec_reject   <= 1'b0;
    end else begin
      r_ld_note_q    <= ld_note;
      r_ld_play_q    <= ld_play;
      r_rec_reject   <= w_rej;
      r_disp_ld_play <= w_show;
      if (clear) begin
        r_count <= '0;
        r_idx   <= '0;
      end else begin
        if (w_wr)         r_count <= r_count + LP_ONE;
        if (w_start)      r_idx   <= '0;
        else if (w_adv)   r_idx   <= r_idx + ADDR_W'(1);
      end
      if (w_show)
        r_tick <= LP_TICK;
      else if (r_state == S_PLAY_HOLD && r_tick != '0)
        r_tick <= r_tick - TICK_W'(1);
      if (r_state == S_IDLE) begin
        r_note         <= note_sw;
        r_octave       <= octave_sw;
        r_disp_ld_note <= ld_note;
      end else begin
        r_disp_ld_note <= 1'b0;
        if (w_show) {r_octave, r_note} <= r_rd;
      end
    end
  end

  assign note         = r_note;
  assign octave       = r_octave;
  assign disp_ld_note = r_disp_ld_note;
  assign disp_ld_play = r_disp_ld_play;
  assign playing      = (r_state != S_IDLE);
  assign count        = r_count;
  assign rec_reject   = r_rec_reject;

endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: table vectors, directed corner sequences and random
// stimulus checked against a schedule-based reference model.
module tb_note_sequencer;

  localparam int DEPTH = 16;
  localparam int TICKS = 4;
  localparam int P     = TICKS + 2;
`ifdef LOOP_PLAY_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic       clk = 0, reset = 0;
  logic [3:0] note_sw = 0;
  logic [1:0] octave_sw = 0;
  logic       ld_note = 0, ld_play = 0, stop = 0, clear = 0;
  logic [3:0] note;
  logic [1:0] octave;
  logic       disp_ld_note, disp_ld_play, playing, rec_reject;
  logic [4:0] count;

  note_sequencer #(.DEPTH(DEPTH), .ADDR_W(4), .NOTE_TICKS(TICKS), .TICK_W(25)) dut (
    .clk(clk), .reset(reset), .note_sw(note_sw), .octave_sw(octave_sw),
    .ld_note(ld_note), .ld_play(ld_play), .stop(stop), .clear(clear),
    .note(note), .octave(octave), .disp_ld_note(disp_ld_note),
    .disp_ld_play(disp_ld_play), .playing(playing), .count(count),
    .rec_reject(rec_reject)
  );

  always #5 clk = ~clk;

  int n_err = 0, n_chk = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // reference model: recording as a queue, playback as a time schedule
  bit [5:0] m_rec[$];
  bit       m_play, m_pn, m_pp;
  int       m_t;
  bit [3:0] m_note;
  bit [1:0] m_oct;
  bit       m_dln, m_dlp, m_rej;

  task automatic m_reset();
    m_rec.delete();
    m_play = 0; m_pn = 0; m_pp = 0; m_t = 0;
    m_note = 0; m_oct = 0; m_dln = 0; m_dlp = 0; m_rej = 0;
  endtask

  task automatic m_step();
    bit evn, evp;
    int n;
    evn = ld_note && !m_pn;
    evp = ld_play && !m_pp;
    m_pn = ld_note;
    m_pp = ld_play;
    m_rej = 0;
    m_dlp = 0;
    if (!m_play) begin
      m_note = note_sw;
      m_oct  = octave_sw;
      m_dln  = ld_note;
      if (clear) m_rec.delete();
      else if (evp && m_rec.size() > 0) begin
        m_play = 1;
        m_t = 0;
      end else if (evn) begin
        if (m_rec.size() < DEPTH && note_sw <= 12) m_rec.push_back({octave_sw, note_sw});
        else m_rej = 1;
      end
    end else begin
      m_dln = 0;
      m_t++;
      n = m_t;
      if (clear) begin
        m_rec.delete();
        m_play = 0;
      end else if (stop) begin
        m_play = 0;
      end else begin
        if (n >= 2 && (n - 2) % P == 0) begin
          m_dlp = 1;
          {m_oct, m_note} = m_rec[((n - 2) / P) % m_rec.size()];
        end
        if (!LOOP && n == m_rec.size() * P) m_play = 0;
      end
    end
  endtask

  task automatic drive_edge(input logic [3:0] n, input logic [1:0] o,
                            input bit ln, input bit lp, input bit sp, input bit cl);
    @(negedge clk);
    note_sw = n; octave_sw = o; ld_note = ln; ld_play = lp; stop = sp; clear = cl;
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic cyc(input logic [3:0] n, input logic [1:0] o,
                     input bit ln, input bit lp, input bit sp, input bit cl);
    drive_edge(n, o, ln, lp, sp, cl);
    chk("note", note, m_note);
    chk("octave", octave, m_oct);
    chk("disp_ld_note", disp_ld_note, m_dln);
    chk("disp_ld_play", disp_ld_play, m_dlp);
    chk("playing", playing, m_play);
    chk("count", count, m_rec.size());
    chk("rec_reject", rec_reject, m_rej);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    note_sw = 0; octave_sw = 0; ld_note = 0; ld_play = 0; stop = 0; clear = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 0;
    m_reset();
  endtask

  typedef struct {
    logic [3:0] n;  logic [1:0] o;  bit ln;  bit lp;
    logic [3:0] en; logic [1:0] eo; bit edln; bit edlp; bit epl; int ecnt; bit erej;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic [3:0] n, input logic [1:0] o, input bit ln, input bit lp,
                     input logic [3:0] en, input logic [1:0] eo, input bit edln,
                     input bit edlp, input bit epl, input int ecnt, input bit erej);
    vec_t v;
    v.n = n; v.o = o; v.ln = ln; v.lp = lp;
    v.en = en; v.eo = eo; v.edln = edln; v.edlp = edlp; v.epl = epl;
    v.ecnt = ecnt; v.erej = erej;
    tbl.push_back(v);
  endtask

  initial begin
    // record two notes, reject an invalid code, then play once
    add(3, 1, 0, 0,  3, 1, 0, 0, 0, 0, 0);
    add(3, 1, 1, 0,  3, 1, 1, 0, 0, 1, 0);
    add(10, 2, 0, 0, 10, 2, 0, 0, 0, 1, 0);
    add(10, 2, 1, 0, 10, 2, 1, 0, 0, 2, 0);
    add(14, 0, 0, 0, 14, 0, 0, 0, 0, 2, 0);
    add(14, 0, 1, 0, 14, 0, 1, 0, 0, 2, 1);
    add(14, 0, 0, 0, 14, 0, 0, 0, 0, 2, 0);
    add(5, 3, 0, 0,  5, 3, 0, 0, 0, 2, 0);
    add(5, 3, 0, 1,  5, 3, 0, 0, 1, 2, 0);
    add(5, 3, 0, 1,  5, 3, 0, 0, 1, 2, 0);
    add(5, 3, 0, 0,  3, 1, 0, 1, 1, 2, 0);
    add(5, 3, 0, 0,  3, 1, 0, 0, 1, 2, 0);
    add(5, 3, 1, 0,  3, 1, 0, 0, 1, 2, 0);
    add(5, 3, 0, 0,  3, 1, 0, 0, 1, 2, 0);
    add(5, 3, 0, 0,  3, 1, 0, 0, 1, 2, 0);
    add(5, 3, 0, 0,  3, 1, 0, 0, 1, 2, 0);
    add(5, 3, 0, 0,  10, 2, 0, 1, 1, 2, 0);
    add(5, 3, 0, 0,  10, 2, 0, 0, 1, 2, 0);
    add(5, 3, 0, 0,  10, 2, 0, 0, 1, 2, 0);
    add(5, 3, 0, 0,  10, 2, 0, 0, 1, 2, 0);
    add(5, 3, 0, 0,  10, 2, 0, 0, LOOP, 2, 0);
    if (LOOP) add(5, 3, 0, 0, 10, 2, 0, 0, 1, 2, 0);
    else      add(5, 3, 0, 0,  5, 3, 0, 0, 0, 2, 0);

    m_reset();
    do_reset();
    chk("rst_note", note, 0);
    chk("rst_playing", playing, 0);
    chk("rst_count", count, 0);
    chk("rst_dlp", disp_ld_play, 0);

    foreach (tbl[i]) begin
      drive_edge(tbl[i].n, tbl[i].o, tbl[i].ln, tbl[i].lp, 0, 0);
      chk($sformatf("tbl%0d_note", i), note, tbl[i].en);
      chk($sformatf("tbl%0d_oct", i), octave, tbl[i].eo);
      chk($sformatf("tbl%0d_dln", i), disp_ld_note, tbl[i].edln);
      chk($sformatf("tbl%0d_dlp", i), disp_ld_play, tbl[i].edlp);
      chk($sformatf("tbl%0d_play", i), playing, tbl[i].epl);
      chk($sformatf("tbl%0d_cnt", i), count, tbl[i].ecnt);
      chk($sformatf("tbl%0d_rej", i), rec_reject, tbl[i].erej);
    end

    // asynchronous reset in the middle of a held note
    do_reset();
    cyc(3, 1, 1, 0, 0, 0);
    cyc(3, 1, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(3, 1, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1;
    #1;
    chk("async_note", note, 0);
    chk("async_oct", octave, 0);
    chk("async_playing", playing, 0);
    chk("async_count", count, 0);
    chk("async_dlp", disp_ld_play, 0);
    @(posedge clk);
    #1;
    chk("async_dlp_hold", disp_ld_play, 0);
    @(negedge clk);
    reset = 0;
    m_reset();

    // fill to capacity, 17th record refused
    for (int i = 0; i < DEPTH + 1; i++) begin
      cyc(4'((i % 12) + 1), 2'(i % 4), 1, 0, 0, 0);
      if (i == DEPTH) chk("full_reject", rec_reject, 1);
      cyc(0, 0, 0, 0, 0, 0);
      if (i == DEPTH - 1) chk("full_count16", count, DEPTH);
    end
    chk("full_count_sat", count, DEPTH);

    // clear, record two, stop during hold
    cyc(0, 0, 0, 0, 0, 1);
    chk("clear_count", count, 0);
    cyc(3, 1, 1, 0, 0, 0);
    cyc(10, 2, 0, 0, 0, 0);
    cyc(10, 2, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("stop_idle", playing, 0);
    chk("stop_count", count, 2);
    // play and record requested in the same cycle
    cyc(7, 0, 1, 1, 0, 0);
    chk("conflict_play", playing, 1);
    chk("conflict_count", count, 2);
    cyc(7, 0, 0, 0, 0, 0);
    cyc(7, 0, 0, 0, 0, 1);
    chk("clr_play_idle", playing, 0);
    chk("clr_play_count", count, 0);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] n;
      bit ln, lp, sp, cl;
      n  = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(13, 15)) : 4'($urandom_range(0, 12));
      ln = ($urandom_range(0, 2) == 0) ? ~ld_note : ld_note;
      lp = ($urandom_range(0, 24) == 0);
      sp = ($urandom_range(0, 59) == 0);
      cl = ($urandom_range(0, 149) == 0);
      cyc(n, 2'($urandom_range(0, 3)), ln, lp, sp, cl);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
